// File: rtl/ghffe_pkg.sv
// Shared histogram geometry, scan FSM states and read-tag payload for the
// histogram peak finder.
package ghffe_pkg;

  localparam int unsigned HIST_DEPTH = 1024;
  localparam int unsigned HIST_AW    = 10;
  localparam int unsigned HIST_DW    = 16;
  localparam int unsigned SUM_W      = HIST_AW + HIST_DW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // One entry of the read-latency delay line, aligned to hdata.
  typedef struct packed {
    logic               vld;
    logic [HIST_AW-1:0] addr;
  } rd_tag_t;

endpackage

// File: rtl/hist_peak_finder_if.sv
// Control, BRAM read port and result bundle of the histogram peak finder.
interface hist_peak_finder_if;
  import ghffe_pkg::*;

  logic               start;
  logic [HIST_DW-1:0] threshold;
  logic [HIST_AW-1:0] haddr;
  logic [HIST_DW-1:0] hdata;
  logic               busy;
  logic               valid;
  logic [HIST_AW-1:0] peak_bin;
  logic [HIST_DW-1:0] peak_mag;
  logic [HIST_DW-1:0] mean_mag;
  logic               detected;

  modport master (
    output start, threshold, hdata,
    input  haddr, busy, valid, peak_bin, peak_mag, mean_mag, detected
  );

  modport slave (
    input  start, threshold, hdata,
    output haddr, busy, valid, peak_bin, peak_mag, mean_mag, detected
  );

endinterface

// File: rtl/hist_peak_finder.sv
// Scans a 1024-bin histogram BRAM after each frame and reports the largest
// eligible bin, the frame mean and an SNR/threshold detection flag.
module hist_peak_finder
  import ghffe_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned BIN_LO     = 1,
  parameter int unsigned BIN_HI     = 1023,
  parameter int unsigned SNR_SHIFT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  hist_peak_finder_if.slave bus
);

  localparam int unsigned CMP_W = HIST_DW + SNR_SHIFT;
  localparam logic [HIST_AW-1:0] LAST_ADDR = HIST_AW'(HIST_DEPTH - 1);

  state_e             state_q, state_d;
  logic [HIST_AW-1:0] haddr_q, haddr_d;
  rd_tag_t            pipe_q [RD_LATENCY];
  rd_tag_t            tag_in, tag;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [HIST_AW-1:0] pk_bin_q, pk_bin_d;
  logic [HIST_DW-1:0] pk_mag_q, pk_mag_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [HIST_AW-1:0] peak_bin_q, peak_bin_d;
  logic [HIST_DW-1:0] peak_mag_q, peak_mag_d;
  logic [HIST_DW-1:0] mean_q, mean_d;
  logic               det_q, det_d;
  logic               in_range;

  assign tag = pipe_q[RD_LATENCY-1];

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    sum_d      = sum_q;
    pk_bin_d   = pk_bin_q;
    pk_mag_d   = pk_mag_q;
    valid_d    = 1'b0;
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    mean_d     = mean_q;
    det_d      = det_q;

    tag_in.vld  = (state_q == ST_SCAN);
    tag_in.addr = haddr_q;

    // Consume the sample returning from the BRAM this cycle.
    in_range = (32'(tag.addr) >= BIN_LO) && (32'(tag.addr) <= BIN_HI);
    if (tag.vld) begin
      sum_d = sum_q + SUM_W'(bus.hdata);
      if (in_range && (bus.hdata > pk_mag_q)) begin
        pk_bin_d = tag.addr;
        pk_mag_d = bus.hdata;
      end
    end

    case (state_q)
      ST_IDLE: begin
        haddr_d = '0;
        if (bus.start) begin
          state_d  = ST_SCAN;
          sum_d    = '0;
          pk_bin_d = HIST_AW'(BIN_LO);
          pk_mag_d = '0;
        end
      end
      ST_SCAN: begin
        if (haddr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          haddr_d = '0;
        end else begin
          haddr_d = haddr_q + HIST_AW'(1);
        end
      end
      ST_DRAIN: begin
        // Results are built from the final accumulators as the last bin lands.
        if (tag.vld && (tag.addr == LAST_ADDR)) begin
          state_d    = ST_DONE;
          valid_d    = 1'b1;
          peak_bin_d = pk_bin_d;
          peak_mag_d = pk_mag_d;
          mean_d     = sum_d[SUM_W-1 -: HIST_DW];
          det_d      = (pk_mag_d > bus.threshold) &&
                       (CMP_W'(pk_mag_d) > (CMP_W'(sum_d[SUM_W-1 -: HIST_DW]) << SNR_SHIFT));
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      sum_q      <= '0;
      pk_bin_q   <= '0;
      pk_mag_q   <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
      mean_q     <= '0;
      det_q      <= 1'b0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      sum_q      <= sum_d;
      pk_bin_q   <= pk_bin_d;
      pk_mag_q   <= pk_mag_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
      mean_q     <= mean_d;
      det_q      <= det_d;
      pipe_q[0]  <= tag_in;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.haddr    = haddr_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.peak_bin = peak_bin_q;
  assign bus.peak_mag = peak_mag_q;
  assign bus.mean_mag = mean_q;
  assign bus.detected = det_q;

endmodule

// File: tb/tb_hist_peak_finder.sv
// Self-checking bench for hist_peak_finder: table of histogram frames with a
// result scoreboard, plus start-while-busy and reset-mid-scan sequences.
module tb_hist_peak_finder;

  localparam int unsigned LAT = 2;
  localparam int unsigned START_TO_VALID = 1025 + LAT;

  typedef struct {
    int          pat;
    logic [15:0] thr;
    logic        use_model;
    logic [9:0]  bin;
    logic [15:0] mag;
    logic [15:0] mean;
    logic        det;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [9:0]  bin;
    logic [15:0] mag;
    logic [15:0] mean;
    logic        det;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned valid_cnt = 0;
  logic [15:0] mem [1024];
  logic [15:0] rd_q [LAT];
  exp_t        sb [$];
  exp_t        mon_e;
  vec_t        vt [8];

  hist_peak_finder_if bus ();

  hist_peak_finder #(
    .RD_LATENCY(LAT),
    .BIN_LO    (1),
    .BIN_HI    (1023),
    .SNR_SHIFT (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM read port model with LAT cycles of latency.
  always @(posedge clk) begin
    rd_q[0] <= mem[bus.haddr];
    for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign bus.hdata = rd_q[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_cycle", cyc, mon_e.due);
        chk("peak_bin", 32'(bus.peak_bin), 32'(mon_e.bin));
        chk("peak_mag", 32'(bus.peak_mag), 32'(mon_e.mag));
        chk("mean_mag", 32'(bus.mean_mag), 32'(mon_e.mean));
        chk("detected", 32'(bus.detected), 32'(mon_e.det));
      end
    end
  end

  task automatic fill(input int pat);
    for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
    case (pat)
      0: mem[200] = 16'd5000;
      1: begin mem[0] = 16'd9000; mem[50] = 16'd3000; mem[60] = 16'd3000; end
      2: begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'd1000;
        mem[300] = 16'd3500;
      end
      3: for (int i = 0; i < 1024; i++) mem[i] = 16'hFFFF;
      5: mem[1023] = 16'd7;
      6: begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom_range(0, 40000));
        mem[0] = 16'hFFFF;
      end
      default: ;
    endcase
  endtask

  task automatic model(input logic [15:0] thr, output exp_t e);
    int unsigned sum;
    sum   = 0;
    e.bin = 10'd1;
    e.mag = 16'd0;
    for (int i = 0; i < 1024; i++) begin
      sum += 32'(mem[i]);
      if (i >= 1 && mem[i] > e.mag) begin
        e.bin = 10'(i);
        e.mag = mem[i];
      end
    end
    e.mean = 16'(sum / 1024);
    e.det  = (e.mag > thr) && (32'(e.mag) > 32'(e.mean) * 4);
  endtask

  task automatic pulse_start(output int unsigned n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int unsigned w;
    w = 0;
    while (sb.size() != 0 && w < START_TO_VALID + 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no valid expected one within %0d cycles", nm, w);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    int unsigned n;
    fill(v.pat);
    bus.threshold = v.thr;
    if (v.use_model) model(v.thr, e);
    else begin
      e.bin = v.bin; e.mag = v.mag; e.mean = v.mean; e.det = v.det;
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    n = cyc;
    e.due = n + START_TO_VALID;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain("scan");
    repeat (3) @(negedge clk);
    chk("hold_peak_mag", 32'(bus.peak_mag), 32'(e.mag));
    chk("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    exp_t        e;
    int unsigned n;
    int unsigned vc0;

    vt[0] = '{pat: 0, thr: 16'd100,  use_model: 1'b0, bin: 10'd200,  mag: 16'd5000,  mean: 16'd4,     det: 1'b1};
    vt[1] = '{pat: 1, thr: 16'd100,  use_model: 1'b0, bin: 10'd50,   mag: 16'd3000,  mean: 16'd14,    det: 1'b1};
    vt[2] = '{pat: 2, thr: 16'd0,    use_model: 1'b0, bin: 10'd300,  mag: 16'd3500,  mean: 16'd1002,  det: 1'b0};
    vt[3] = '{pat: 3, thr: 16'd0,    use_model: 1'b0, bin: 10'd1,    mag: 16'hFFFF,  mean: 16'hFFFF,  det: 1'b0};
    vt[4] = '{pat: 4, thr: 16'd0,    use_model: 1'b0, bin: 10'd1,    mag: 16'd0,     mean: 16'd0,     det: 1'b0};
    vt[5] = '{pat: 5, thr: 16'd5,    use_model: 1'b0, bin: 10'd1023, mag: 16'd7,     mean: 16'd0,     det: 1'b1};
    vt[6] = '{pat: 0, thr: 16'd5000, use_model: 1'b0, bin: 10'd200,  mag: 16'd5000,  mean: 16'd4,     det: 1'b0};
    vt[7] = '{pat: 6, thr: 16'd20000, use_model: 1'b1, bin: 10'd0,   mag: 16'd0,     mean: 16'd0,     det: 1'b0};

    bus.start     = 1'b0;
    bus.threshold = 16'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
    for (int i = 0; i < LAT; i++) rd_q[i] = 16'd0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_haddr", 32'(bus.haddr), 0);
    chk("rst_peak_bin", 32'(bus.peak_bin), 0);
    chk("rst_peak_mag", 32'(bus.peak_mag), 0);
    chk("rst_mean_mag", 32'(bus.mean_mag), 0);
    chk("rst_detected", 32'(bus.detected), 0);

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Second start at cycle 500 of a scan must be ignored.
    fill(0);
    bus.threshold = 16'd100;
    vc0 = valid_cnt;
    e = '{due: 0, bin: 10'd200, mag: 16'd5000, mean: 16'd4, det: 1'b1};
    pulse_start(n);
    e.due = n + START_TO_VALID;
    sb.push_back(e);
    chk("scan_busy", 32'(bus.busy), 1);
    chk("scan_haddr0", 32'(bus.haddr), 0);
    @(posedge clk); #1;
    chk("scan_haddr1", 32'(bus.haddr), 1);
    while (cyc < n + 500) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_drain("busy_start");
    repeat (600) @(negedge clk);
    chk("single_valid", valid_cnt - vc0, 1);

    // Reset during the scan aborts it silently.
    fill(2);
    bus.threshold = 16'd0;
    vc0 = valid_cnt;
    pulse_start(n);
    while (cyc < n + 600) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_haddr", 32'(bus.haddr), 0);
    chk("abort_peak_bin", 32'(bus.peak_bin), 0);
    chk("abort_peak_mag", 32'(bus.peak_mag), 0);
    chk("abort_mean_mag", 32'(bus.mean_mag), 0);
    chk("abort_detected", 32'(bus.detected), 0);
    repeat (START_TO_VALID + 50) @(negedge clk);
    chk("abort_no_valid", valid_cnt - vc0, 0);
    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
